// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: request/response bundle between an initiator and the SRAM responder.
// Latency: none (wires only); the responder sets the request-to-data_ok timing.
// Backpressure: the initiator holds req and its fields stable until it sees req && addr_ok.
// Signals: req/wr/size/addr/wstrb/wdata travel to the responder; addr_ok/data_ok/rdata return.
interface data_sram_resp_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp: word-addressed SRAM answering one request at a time with a data_ok strobe.
// Latency: data_ok LATENCY cycles after acceptance (LATENCY..LATENCY+3 with DSRAM_RAND_DELAY_EN).
// Backpressure: addr_ok drops while a request is waiting; it rises again in the response cycle.
// Ports: clk, reset (async, active high); bus (slave modport: req/wr/size/addr/wstrb/wdata in,
//        addr_ok/data_ok/rdata out); size_dbg_o shows the size field of the latest accepted request.
// Optional macro DSRAM_RAND_DELAY_EN adds a 0..3 cycle LFSR-driven jitter to every response.
module data_sram_resp #(
  parameter int IDX_W   = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  data_sram_resp_if.slave   bus,
  output logic [1:0]        size_dbg_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;

  logic [31:0] mem [0:DEPTH-1];

  logic [IDX_W-1:0] idx;
  logic             acc;
  logic [31:0]      acc_word;
  logic [1:0]       extra;
  logic [3:0]       eff_lat;
  logic             direct;
  logic [3:0]       load_val;

  // Upper and byte-offset address bits are dropped, so the array aliases across the space.
  assign idx = bus.addr[IDX_W+1:2];

  // Reset blocks acceptance so a request presented during reset cannot touch memory.
  assign acc = bus.req && bus.addr_ok && !reset;

  // Writes answer with zero; reads answer with the word as it stands at the acceptance edge.
  assign acc_word = bus.wr ? 32'd0 : mem[idx];

`ifdef DSRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci LFSR, taps 16/14/13/11: maximal length, free-running every cycle.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'd0;
`endif

  // Effective latency of this request; a counter value of N gives N+2 cycles to data_ok.
  assign eff_lat  = 4'(LATENCY) + {2'b00, extra};
  assign direct   = (eff_lat == 4'd1);
  assign load_val = eff_lat - 4'd2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    case (state_q)
      IDLE, RESP: begin
        if (acc) begin
          resp_d = acc_word;
          size_d = bus.size;
          if (direct) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            rdata_d = acc_word;
          end else begin
            state_d = WAIT;
            cnt_d   = load_val;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = resp_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // rdata_q is loaded on the edge into RESP and then simply held, which gives the
  // "drive in RESP, keep last value elsewhere" behaviour without an output mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= 32'd0;
      rdata_q <= 32'd0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
    end
  end

  // Storage is deliberately not reset; committed writes survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (acc && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.addr_ok = (state_q != WAIT);
  assign bus.data_ok = (state_q == RESP);
  assign bus.rdata   = rdata_q;
  assign size_dbg_o  = size_q;

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_s   [2];
  logic        req_s   [2];
  logic        wr_s    [2];
  logic [1:0]  size_s  [2];
  logic [31:0] addr_s  [2];
  logic [3:0]  wstrb_s [2];
  logic [31:0] wdata_s [2];
  logic        aok_s   [2];
  logic        dok_s   [2];
  logic [31:0] rd_s    [2];
  logic [1:0]  dbg_s   [2];

  data_sram_resp_if bus0 ();
  data_sram_resp_if bus1 ();

  assign bus0.req   = req_s[0];
  assign bus0.wr    = wr_s[0];
  assign bus0.size  = size_s[0];
  assign bus0.addr  = addr_s[0];
  assign bus0.wstrb = wstrb_s[0];
  assign bus0.wdata = wdata_s[0];
  assign aok_s[0]   = bus0.addr_ok;
  assign dok_s[0]   = bus0.data_ok;
  assign rd_s[0]    = bus0.rdata;

  assign bus1.req   = req_s[1];
  assign bus1.wr    = wr_s[1];
  assign bus1.size  = size_s[1];
  assign bus1.addr  = addr_s[1];
  assign bus1.wstrb = wstrb_s[1];
  assign bus1.wdata = wdata_s[1];
  assign aok_s[1]   = bus1.addr_ok;
  assign dok_s[1]   = bus1.data_ok;
  assign rd_s[1]    = bus1.rdata;

  logic [1:0] dbg0, dbg1;
  assign dbg_s[0] = dbg0;
  assign dbg_s[1] = dbg1;

  data_sram_resp #(.IDX_W(10), .LATENCY(1)) dut0 (
    .clk(clk), .reset(rst_s[0]), .bus(bus0), .size_dbg_o(dbg0)
  );

  data_sram_resp #(.IDX_W(10), .LATENCY(3)) dut1 (
    .clk(clk), .reset(rst_s[1]), .bus(bus1), .size_dbg_o(dbg1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] pv(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507) ^ 32'h0000_0001;
  endfunction

  // Reference model: one pending response per lane, due at a fixed cycle number.
  int          lat_of [2] = '{1, 3};
  bit          pend   [2];
  int          due    [2];
  logic [31:0] pdata  [2];
  logic [31:0] last   [2];
  logic [31:0] mm     [2][1024];
  bit          done = 1'b0;

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst_s[k]) begin
        chk($sformatf("m%0d_rst_addr_ok", k), 32'(aok_s[k]), 32'd1);
        chk($sformatf("m%0d_rst_data_ok", k), 32'(dok_s[k]), 32'd0);
        chk($sformatf("m%0d_rst_rdata", k), rd_s[k], 32'd0);
        pend[k] = 1'b0;
        last[k] = 32'd0;
      end else begin
        bit          e_ok, e_dv;
        logic [31:0] e_rd;
        int          ix;
        e_ok = !pend[k] || (cyc == due[k]);
        e_dv = pend[k] && (cyc == due[k]);
        e_rd = e_dv ? pdata[k] : last[k];
        chk($sformatf("m%0d_addr_ok", k), 32'(aok_s[k]), 32'(e_ok));
        chk($sformatf("m%0d_data_ok", k), 32'(dok_s[k]), 32'(e_dv));
        chk($sformatf("m%0d_rdata", k), rd_s[k], e_rd);
        if (e_dv) begin
          last[k] = pdata[k];
          pend[k] = 1'b0;
        end
        if (req_s[k] && e_ok) begin
          ix = int'(addr_s[k] >> 2) % 1024;
          if (wr_s[k]) begin
            for (int b = 0; b < 4; b++)
              if (wstrb_s[k][b]) mm[k][ix][8*b +: 8] = wdata_s[k][8*b +: 8];
            pdata[k] = 32'd0;
          end else begin
            pdata[k] = mm[k][ix];
          end
          pend[k] = 1'b1;
          due[k]  = cyc + lat_of[k];
        end
      end
    end
  endtask

  // One complete request on lane k; checks latency, response word and recorded size.
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd, input string nm);
    int t0, n;
    logic [1:0] sz;
    sz = 2'($urandom_range(0, 2));
    @(posedge clk); #1;
    req_s[k] = 1'b1; wr_s[k] = w; addr_s[k] = a; wstrb_s[k] = s; wdata_s[k] = d; size_s[k] = sz;
    n = 0;
    do begin @(negedge clk); n++; end while (!aok_s[k] && n < 40);
    if (!aok_s[k]) begin
      chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1 req_s[k] = 1'b0;
      return;
    end
    t0 = cyc;
    @(posedge clk); #1 req_s[k] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!dok_s[k] && n < 20);
    chk({nm, "_data_ok"}, 32'(dok_s[k]), 32'd1);
    chk({nm, "_latency"}, 32'(cyc - t0), 32'(lat_of[k]));
    chk({nm, "_rdata"}, rd_s[k], exp_rd);
    chk({nm, "_size_dbg"}, 32'(dbg_s[k]), 32'(sz));
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  task automatic rand_run(input int k, input int ncyc);
    bit held = 1'b0;
    int ix;
    repeat (ncyc) begin
      @(posedge clk); #1;
      if (!held) begin
        if ($urandom_range(0, 2) != 0) begin
          ix = $urandom_range(0, 15);
          req_s[k]   = 1'b1;
          wr_s[k]    = 1'($urandom_range(0, 1));
          addr_s[k]  = ($urandom & 32'hFFFF_F003) | (32'(ix) << 2);
          wstrb_s[k] = 4'($urandom);
          wdata_s[k] = $urandom;
          size_s[k]  = 2'($urandom_range(0, 2));
          held = 1'b1;
        end else begin
          req_s[k] = 1'b0;
        end
      end
      @(negedge clk);
      if (req_s[k] && aok_s[k]) held = 1'b0;
    end
    @(posedge clk); #1 req_s[k] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    vec_t tbl [12];
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; req_s[k] = 1'b0; wr_s[k] = 1'b0; size_s[k] = 2'd0;
      addr_s[k] = 32'd0; wstrb_s[k] = 4'd0; wdata_s[k] = 32'd0;
      pend[k] = 1'b0; due[k] = 0; pdata[k] = 32'd0; last[k] = 32'd0;
    end

    tbl[0]  = '{1'b1, 32'h0000_0100, 4'hF,    32'h1122_3344, 32'h0000_0000};
    tbl[1]  = '{1'b0, 32'h0000_0100, 4'h0,    32'h0000_0000, 32'h1122_3344};
    tbl[2]  = '{1'b1, 32'h0000_0100, 4'b1000, 32'hAA00_0000, 32'h0000_0000};
    tbl[3]  = '{1'b0, 32'h0000_0102, 4'h0,    32'h0000_0000, 32'hAA22_3344};
    tbl[4]  = '{1'b1, 32'h1000_0004, 4'hF,    32'h5A5A_5A5A, 32'h0000_0000};
    tbl[5]  = '{1'b0, 32'h0000_0004, 4'h0,    32'h0000_0000, 32'h5A5A_5A5A};
    tbl[6]  = '{1'b1, 32'h0000_003C, 4'hF,    32'hCAFE_F00D, 32'h0000_0000};
    tbl[7]  = '{1'b1, 32'h0000_003C, 4'h0,    32'hFFFF_FFFF, 32'h0000_0000};
    tbl[8]  = '{1'b0, 32'h0000_003F, 4'h0,    32'h0000_0000, 32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 32'h0000_003C, 4'b0101, 32'h0011_0022, 32'h0000_0000};
    tbl[10] = '{1'b0, 32'h0000_003C, 4'h0,    32'h0000_0000, 32'hCA11_F022};
    tbl[11] = '{1'b0, 32'hFFFF_F03C, 4'h0,    32'h0000_0000, 32'hCA11_F022};

    fork
      begin
        while (!done) begin
          @(negedge clk);
          model_step();
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 rst_s[0] = 1'b0; rst_s[1] = 1'b0;

        // Known contents for words 0..15 on both lanes.
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < 16; i++)
            issue(k, 1'b1, 32'(i * 4), 4'hF, pv(i), 32'd0, $sformatf("init%0d_%0d", k, i));

        // LATENCY=1, req held for four reads: four consecutive data_ok cycles.
        @(posedge clk); #1;
        req_s[0] = 1'b1; wr_s[0] = 1'b0; addr_s[0] = 32'h0; wstrb_s[0] = 4'h0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("b2b_addr_ok", 32'(aok_s[0]), 32'd1);
          if (i > 0) begin
            chk("b2b_data_ok", 32'(dok_s[0]), 32'd1);
            chk("b2b_rdata", rd_s[0], pv(i - 1));
          end
          @(posedge clk); #1;
          if (i < 3) addr_s[0] = 32'((i + 1) * 4);
          else req_s[0] = 1'b0;
        end
        @(negedge clk);
        chk("b2b_data_ok_last", 32'(dok_s[0]), 32'd1);
        chk("b2b_rdata_last", rd_s[0], pv(3));
        @(negedge clk);
        chk("b2b_data_ok_end", 32'(dok_s[0]), 32'd0);

        // LATENCY=3 timing, with the initiator holding a second read through WAIT.
        @(posedge clk); #1;
        req_s[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = 32'h14; wstrb_s[1] = 4'h0;
        @(negedge clk);
        chk("l3_T_addr_ok", 32'(aok_s[1]), 32'd1);
        @(posedge clk); #1 addr_s[1] = 32'h18;
        @(negedge clk);
        chk("l3_T1_addr_ok", 32'(aok_s[1]), 32'd0);
        chk("l3_T1_data_ok", 32'(dok_s[1]), 32'd0);
        @(negedge clk);
        chk("l3_T2_addr_ok", 32'(aok_s[1]), 32'd0);
        chk("l3_T2_data_ok", 32'(dok_s[1]), 32'd0);
        @(negedge clk);
        chk("l3_T3_addr_ok", 32'(aok_s[1]), 32'd1);
        chk("l3_T3_data_ok", 32'(dok_s[1]), 32'd1);
        chk("l3_T3_rdata", rd_s[1], pv(5));
        @(posedge clk); #1 req_s[1] = 1'b0;
        @(negedge clk);
        chk("l3_T4_addr_ok", 32'(aok_s[1]), 32'd0);
        chk("l3_T4_rdata_hold", rd_s[1], pv(5));
        @(negedge clk);
        chk("l3_T5_data_ok", 32'(dok_s[1]), 32'd0);
        @(negedge clk);
        chk("l3_T6_data_ok", 32'(dok_s[1]), 32'd1);
        chk("l3_T6_rdata", rd_s[1], pv(6));
        @(negedge clk);
        chk("l3_T7_data_ok", 32'(dok_s[1]), 32'd0);
        chk("l3_T7_addr_ok", 32'(aok_s[1]), 32'd1);

        // Directed vectors on both lanes.
        for (int k = 0; k < 2; k++)
          for (int v = 0; v < 12; v++)
            issue(k, tbl[v].w, tbl[v].a, tbl[v].s, tbl[v].d, tbl[v].e, $sformatf("vec%0d_%0d", k, v));

        // Reset while a write waits: no data_ok, rdata cleared, the write stays committed.
        issue(1, 1'b0, 32'h1C, 4'h0, 32'd0, pv(7), "pre_rst");
        @(posedge clk); #1;
        req_s[1] = 1'b1; wr_s[1] = 1'b1; addr_s[1] = 32'h24; wstrb_s[1] = 4'hF; wdata_s[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_accept_addr_ok", 32'(aok_s[1]), 32'd1);
        @(posedge clk); #1;
        req_s[1] = 1'b0; rst_s[1] = 1'b1;
        @(negedge clk);
        chk("rst_data_ok", 32'(dok_s[1]), 32'd0);
        chk("rst_rdata", rd_s[1], 32'd0);
        @(posedge clk); #1 rst_s[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("post_rst_no_data_ok", 32'(dok_s[1]), 32'd0);
          chk("post_rst_addr_ok", 32'(aok_s[1]), 32'd1);
        end
        issue(1, 1'b0, 32'h24, 4'h0, 32'd0, 32'hDEAD_BEEF, "post_rst_read");

        // Random traffic against the model.
        rand_run(0, 600);
        rand_run(1, 600);

        done = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
